// File: rtl/gpio.sv
// ----------------------------------------------------------------------------
// gpio: memory-mapped GPIO peripheral, 4-word window selected by A[1:0].
//   A=00 -> GPI1 (read-only), A=01 -> GPI2 (read-only),
//   A=10 -> GPO1 register (r/w), A=11 -> GPO2 register (r/w).
// Ports:
//   CLK, RST_N   clock / async active-low reset
//   WD           write data from CPU
//   GPI1, GPI2   input pins (already synchronized upstream)
//   A, WE        word address and decoder-qualified write enable
//   RD           combinational read data
//   GPO1, GPO2   registered output pins
// ----------------------------------------------------------------------------

// One output register: async reset to RST_VAL, load on wr_en.
module gpio_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     q <= RST_VAL;
        else if (wr_en) q <= wd;
    end
endmodule

module gpio #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  GPO1_RST = '0,
    parameter logic [DATA_W-1:0]  GPO2_RST = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] WD,
    input  logic [DATA_W-1:0] GPI1,
    input  logic [DATA_W-1:0] GPI2,
    input  logic [1:0]        A,
    input  logic              WE,
    output logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] GPO1,
    output logic [DATA_W-1:0] GPO2
);
    localparam int NUM_GPO = 2;
    localparam logic [NUM_GPO-1:0][DATA_W-1:0] RST_VALS = {GPO2_RST, GPO1_RST};

    logic [NUM_GPO-1:0][DATA_W-1:0] gpo_q;
    logic [NUM_GPO-1:0]             wr_sel;

    // A[1] selects the output half of the map, A[0] picks which register;
    // the selects are one-hot so a single edge never loads both.
    always_comb begin
        wr_sel = '0;
        if (WE && A[1]) wr_sel[A[0]] = 1'b1;
    end

    for (genvar i = 0; i < NUM_GPO; i++) begin : g_gpo
        gpio_reg #(
            .DATA_W (DATA_W),
            .RST_VAL(RST_VALS[i])
        ) u_reg (
            .CLK  (CLK),
            .RST_N(RST_N),
            .wr_en(wr_sel[i]),
            .wd   (WD),
            .q    (gpo_q[i])
        );
    end

    assign GPO1 = gpo_q[0];
    assign GPO2 = gpo_q[1];

    // Pure combinational read mux; WE has no influence on RD.
    always_comb begin
        RD = '0;
        case (A)
            2'b00:   RD = GPI1;
            2'b01:   RD = GPI2;
            2'b10:   RD = gpo_q[0];
            default: RD = gpo_q[1];
        endcase
    end
endmodule

// File: tb/tb_gpio.sv
module tb_gpio;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [DATA_W-1:0] WD, GPI1, GPI2;
    logic [1:0]        A;
    logic              WE;
    logic [DATA_W-1:0] RD, GPO1, GPO2;

    int tests = 0;
    int fails = 0;

    // Reference state: the two output registers as plain variables.
    logic [DATA_W-1:0] m_gpo1, m_gpo2;

    gpio #(.DATA_W(DATA_W), .GPO1_RST('0), .GPO2_RST('0)) dut (
        .CLK(CLK), .RST_N(RST_N), .WD(WD), .GPI1(GPI1), .GPI2(GPI2),
        .A(A), .WE(WE), .RD(RD), .GPO1(GPO1), .GPO2(GPO2)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    // Expected read data from the address map.
    function automatic logic [DATA_W-1:0] exp_rd(input logic [1:0] a);
        logic [DATA_W-1:0] win [4];
        win[0] = GPI1; win[1] = GPI2; win[2] = m_gpo1; win[3] = m_gpo2;
        return win[a];
    endfunction

    // Clock one edge; model applies the write rules, then sample 1ns later.
    task automatic tick();
        @(posedge CLK);
        if (RST_N && WE && A == 2'd2) m_gpo1 = WD;
        if (RST_N && WE && A == 2'd3) m_gpo2 = WD;
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; WE = 1'b0; A = 2'd2; WD = '0; GPI1 = '0; GPI2 = '0;
        m_gpo1 = '0; m_gpo2 = '0;
        #12;
        tests++;
        if (GPO1 !== '0 || GPO2 !== '0) begin
            fails++; $display("FAIL reset_state: GPO1=%h GPO2=%h expected 0", GPO1, GPO2);
        end
        tests++;
        if (RD !== '0) begin fails++; $display("FAIL reset_rd_a10: got %h expected 0", RD); end
        A = 2'd3; #1;
        tests++;
        if (RD !== '0) begin fails++; $display("FAIL reset_rd_a11: got %h expected 0", RD); end
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_write_gpo2();
        WE = 1'b1; A = 2'd3; WD = 32'h17;
        tick(); WE = 1'b0; #1;
        tests++;
        if (GPO2 !== 32'h17 || RD !== 32'h17 || GPO1 !== m_gpo1) begin
            fails++; $display("FAIL write_gpo2: GPO2=%h RD=%h GPO1=%h expected 17/17/%h", GPO2, RD, GPO1, m_gpo1);
        end
    endtask

    task automatic test_write_gpo1();
        WE = 1'b1; A = 2'd2; WD = 32'h16;
        tick(); WE = 1'b0; #1;
        tests++;
        if (GPO1 !== 32'h16 || RD !== 32'h16 || GPO2 !== 32'h17) begin
            fails++; $display("FAIL write_gpo1: GPO1=%h RD=%h GPO2=%h expected 16/16/17", GPO1, RD, GPO2);
        end
    endtask

    task automatic test_write_input();
        WE = 1'b1; A = 2'd0; WD = 32'h14; GPI1 = 32'h24; GPI2 = 32'h45;
        tick();
        tests++;
        if (RD !== 32'h24 || GPO1 !== 32'h16 || GPO2 !== 32'h17) begin
            fails++; $display("FAIL write_a00: RD=%h GPO1=%h GPO2=%h expected 24/16/17", RD, GPO1, GPO2);
        end
        A = 2'd1;
        tick();
        tests++;
        if (RD !== 32'h45 || GPO1 !== 32'h16 || GPO2 !== 32'h17) begin
            fails++; $display("FAIL write_a01: RD=%h GPO1=%h GPO2=%h expected 45/16/17", RD, GPO1, GPO2);
        end
        WE = 1'b0;
    endtask

    task automatic test_reads();
        logic [DATA_W-1:0] exp [4];
        exp[0] = 32'h24; exp[1] = 32'h45; exp[2] = 32'h16; exp[3] = 32'h17;
        WE = 1'b0;
        for (int a = 0; a < 4; a++) begin
            A = 2'(a); WD = $urandom;
            tick();
            tests++;
            if (RD !== exp[a] || GPO1 !== 32'h16 || GPO2 !== 32'h17) begin
                fails++; $display("FAIL read_a%0d: RD=%h expected %h GPO1=%h GPO2=%h", a, RD, exp[a], GPO1, GPO2);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            WE = 1'($urandom); A = 2'($urandom); WD = $urandom;
            GPI1 = $urandom; GPI2 = $urandom;
            #1;
            tests++;
            if (RD !== exp_rd(A)) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_rd[%0d]: A=%0d RD=%h expected %h", i, A, RD, exp_rd(A));
            end
            tick();
            tests++;
            if (GPO1 !== m_gpo1 || GPO2 !== m_gpo2) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_gpo[%0d]: GPO1=%h GPO2=%h expected %h/%h", i, GPO1, GPO2, m_gpo1, m_gpo2);
            end
        end
        WE = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        WE = 1'b1; A = 2'd2; WD = v1;
        tick();
        A = 2'd3; WD = v2;
        tick();
        WE = 1'b0; A = 2'd2; #1;
        tests++;
        if (GPO1 !== v1 || GPO2 !== v2 || RD !== v1) begin
            fails++; $display("FAIL back_to_back: GPO1=%h GPO2=%h RD=%h expected %h/%h/%h", GPO1, GPO2, RD, v1, v2, v1);
        end
    endtask

    task automatic test_async_reset();
        WE = 1'b1; A = 2'd3; WD = 32'hDEAD_BEEF;
        tick();
        WE = 1'b0;
        @(posedge CLK); #3;
        RST_N = 1'b0; #1;
        m_gpo1 = '0; m_gpo2 = '0;
        tests++;
        if (GPO1 !== '0 || GPO2 !== '0) begin
            fails++; $display("FAIL async_reset: GPO1=%h GPO2=%h expected 0 without an edge", GPO1, GPO2);
        end
        WE = 1'b1; A = 2'd2; WD = 32'hFFFF_FFFF;
        tick();
        A = 2'd3;
        tick();
        tests++;
        if (GPO1 !== '0 || GPO2 !== '0 || RD !== '0) begin
            fails++; $display("FAIL write_in_reset: GPO1=%h GPO2=%h RD=%h expected 0", GPO1, GPO2, RD);
        end
        WE = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        WE = 1'b1; A = 2'd2; WD = 32'h1234_5678;
        tick(); WE = 1'b0; #1;
        tests++;
        if (GPO1 !== 32'h1234_5678 || GPO2 !== '0) begin
            fails++; $display("FAIL after_reset_write: GPO1=%h GPO2=%h expected 12345678/0", GPO1, GPO2);
        end
    endtask

    initial begin
        test_reset();
        test_write_gpo2();
        test_write_gpo1();
        test_write_input();
        test_reads();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
